fifo_tx_rd_ctrl: RTL and testbench

- Read-side controller for the async FIFO, running in the read clock domain.
- Pulls {last, data} words from the FIFO under empty/read-enable control and absorbs the FIFO's 1-cycle registered read latency with a 2-entry prefetch buffer.
- Presents the words as an AXI-Stream master to the TX MAC.
- Enforces a programmable inter-frame gap after every tlast beat and counts completed frames.

---
 rtl/fifo_ctrl_pkg.sv | 24 ++
 rtl/rd_prefetch_buf.sv | 60 ++++++
 rtl/fifo_tx_rd_ctrl.sv | 124 ++++++++++++
 tb/tb_fifo_tx_rd_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared types and helpers for the FIFO read-side TX controller
// Purpose: state encoding, prefetch depth and the frame-last extraction helper.
// Ports: none (package).
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

  // Upper bound on FIFO word width accepted by word_last; callers zero-extend.
  localparam int MAX_WORD_W = 1024;
  localparam int IDX_W      = $clog2(MAX_WORD_W);

  // The frame-last flag sits just above the payload bits.
  function automatic logic word_last(input logic [MAX_WORD_W-1:0] word,
                                     input logic [IDX_W-1:0]      data_width);
    return word[data_width];
  endfunction

endpackage

// File: rtl/rd_prefetch_buf.sv
// rtl/rd_prefetch_buf.sv - two-entry {last, data} prefetch buffer
// Purpose: holds words returned by the FIFO until the stream accepts them.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   push        - write push_word this cycle
//   push_word   - incoming {last, data} word
//   pop         - drop the head word this cycle
//   head_word   - oldest stored word (entry 0)
//   occ         - number of stored words, 0..2
module rd_prefetch_buf
  import fifo_ctrl_pkg::*;
#(
  parameter int WORD_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] push_word,
  input  logic              pop,
  output logic [WORD_W-1:0] head_word,
  output logic [1:0]        occ
);

  logic [WORD_W-1:0] entry0;
  logic [WORD_W-1:0] entry1;

  // Entry 0 is always the head, so the stream output never needs a mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry0 <= '0;
      entry1 <= '0;
      occ    <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) entry0 <= push_word;
          else             entry1 <= push_word;
          if (occ != 2'(BUF_DEPTH)) occ <= occ + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          // occ stays unchanged; the credit rule keeps occ below 2 here.
          if (occ == 2'd1) begin
            entry0 <= push_word;
          end else begin
            entry0 <= entry1;
            entry1 <= push_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_word = entry0;

endmodule

// File: rtl/fifo_tx_rd_ctrl.sv
// rtl/fifo_tx_rd_ctrl.sv - async FIFO read-side controller driving an AXI-Stream TX MAC
// Purpose: prefetches FIFO words, streams them out, enforces an inter-frame gap and counts frames.
// Ports:
//   clk, reset       - read-domain clock, asynchronous active-high reset
//   fifo_rd_data     - FIFO word {last, data}, valid the cycle after fifo_rd_en
//   fifo_empty       - FIFO empty flag
//   fifo_rd_en       - FIFO read enable
//   m_axis_*         - stream master (tdata, tlast, tvalid, tready)
//   enable           - permits the start of a new frame
//   busy             - state machine is outside IDLE
//   frame_count      - completed frames, wraps
module fifo_tx_rd_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IFG_CYCLES = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH:0]   fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  enable,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  localparam int WORD_W = DATA_WIDTH + 1;
  localparam int GAP_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;
  localparam state_t AFTER_LAST = (IFG_CYCLES == 0) ? IDLE : GAP;

  state_t            state;
  state_t            next_state;
  logic              inflight;
  logic [1:0]        occ;
  logic [WORD_W-1:0] head_word;
  logic              head_last;
  logic              pop;
  logic              last_beat;
  logic [2:0]        credit_used;
  logic [GAP_W-1:0]  gap_cnt;

  rd_prefetch_buf #(
    .WORD_W (WORD_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_word (fifo_rd_data),
    .pop       (pop),
    .head_word (head_word),
    .occ       (occ)
  );

  assign head_last    = word_last(MAX_WORD_W'(head_word), IDX_W'(DATA_WIDTH));
  assign m_axis_tdata = head_word[DATA_WIDTH-1:0];
  assign m_axis_tlast = head_last;

  // Credits count stored words plus the read still in the FIFO pipeline; a
  // pop this cycle frees a slot early so back-to-back beats keep 1/cycle.
  assign credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en  = !fifo_empty && (credit_used < 3'(BUF_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) inflight <= 1'b0;
    else       inflight <= fifo_rd_en;
  end

  // Stream valid: IDLE waits for enable, STREAM ignores it so frames finish.
  always_comb begin
    m_axis_tvalid = 1'b0;
    case (state)
      IDLE:    m_axis_tvalid = enable && (occ != 2'd0);
      STREAM:  m_axis_tvalid = (occ != 2'd0);
      default: m_axis_tvalid = 1'b0;
    endcase
  end

  assign pop       = m_axis_tvalid && m_axis_tready;
  assign last_beat = pop && head_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, STREAM: begin
        if (pop) next_state = head_last ? AFTER_LAST : STREAM;
      end
      GAP: begin
        if (gap_cnt == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Loaded on the tlast beat so GAP holds for exactly IFG_CYCLES cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (last_beat) begin
      gap_cnt <= GAP_LOAD;
    end else if ((state == GAP) && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          frame_count <= '0;
    else if (last_beat) frame_count <= frame_count + CNT_WIDTH'(1);
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_tx_rd_ctrl.sv
// tb/tb_fifo_tx_rd_ctrl.sv - self-checking bench for fifo_tx_rd_ctrl
module tb_fifo_tx_rd_ctrl;

  localparam int DW  = 8;
  localparam int IFG = 12;
  localparam int CW  = 2;
  localparam int WW  = DW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [WW-1:0] fifo_rd_data = '0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          enable;
  logic          busy;
  logic [CW-1:0] frame_count;

  always #5 clk = ~clk;

  fifo_tx_rd_ctrl #(
    .DATA_WIDTH (DW),
    .IFG_CYCLES (IFG),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .enable        (enable),
    .busy          (busy),
    .frame_count   (frame_count)
  );

  // FIFO model: words written by the stimulus, read with one cycle latency.
  logic [WW-1:0] fifo_mem [0:1023];
  int            wr_total = 0;
  int            rd_total = 0;
  logic          force_empty = 1'b0;

  assign fifo_empty = force_empty || (wr_total == rd_total);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= fifo_mem[rd_total[9:0]];
      rd_total     <= rd_total + 1;
    end
  end

  // Reference model state: expected beats, frame/gap bookkeeping.
  logic [WW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            rd_cnt = 0;
  int            beat_cnt = 0;
  int            model_frames = 0;
  bit            in_frame = 0;
  int            gap_left = 0;
  bit            prev_stall = 0;
  logic [WW-1:0] prev_word = '0;
  logic          s_rd_en, s_tvalid, s_busy, s_hs;
  logic [WW-1:0] s_word;

  task automatic model_reset();
    exp_q.delete();
    model_frames = 0;
    in_frame     = 0;
    gap_left     = 0;
    prev_stall   = 0;
    rd_cnt       = 0;
    beat_cnt     = 0;
  endtask

  task automatic push_word(input logic [DW-1:0] data, input logic last);
    fifo_mem[wr_total[9:0]] = {last, data};
    exp_q.push_back({last, data});
    wr_total = wr_total + 1;
  endtask

  task automatic push_rand_frame(input int len);
    for (int i = 0; i < len; i++) push_word(DW'($urandom), (i == len - 1));
  endtask

  // One clock: sample at the falling edge, check against the model, return after the rising edge.
  task automatic tick();
    logic [WW-1:0] got;
    logic [WW-1:0] exp_w;
    @(negedge clk);
    cyc++;
    s_rd_en  = fifo_rd_en;
    s_tvalid = m_axis_tvalid;
    s_busy   = busy;
    s_hs     = m_axis_tvalid && m_axis_tready;
    got      = {m_axis_tlast, m_axis_tdata};
    s_word   = got;
    if (!reset) begin
      checks++;
      if (fifo_rd_en && fifo_empty) begin
        errors++;
        $display("FAIL rd_en_while_empty: cycle %0d rd_en=%0b expected 0", cyc, fifo_rd_en);
      end
      if (fifo_rd_en) rd_cnt++;
      if (s_hs) beat_cnt++;
      checks++;
      if ((rd_cnt - beat_cnt) > 2 || (rd_cnt - beat_cnt) < 0) begin
        errors++;
        $display("FAIL outstanding: cycle %0d got %0d expected 0..2", cyc, rd_cnt - beat_cnt);
      end
      checks++;
      if (busy !== (in_frame || gap_left > 0)) begin
        errors++;
        $display("FAIL busy: cycle %0d got %0b expected %0b", cyc, busy, (in_frame || gap_left > 0));
      end
      checks++;
      if (frame_count !== CW'(model_frames)) begin
        errors++;
        $display("FAIL frame_count: cycle %0d got %0d expected %0d", cyc, frame_count, CW'(model_frames));
      end
      if (gap_left > 0) begin
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL gap_tvalid: cycle %0d got %0b expected 0", cyc, m_axis_tvalid);
        end
      end else if (!in_frame && !enable) begin
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL idle_disabled_tvalid: cycle %0d got %0b expected 0", cyc, m_axis_tvalid);
        end
      end
      if (prev_stall && (in_frame || enable)) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || got !== prev_word) begin
          errors++;
          $display("FAIL stall_hold: cycle %0d got valid=%0b word=%0h expected valid=1 word=%0h",
                   cyc, m_axis_tvalid, got, prev_word);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = got;
      if (s_hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: cycle %0d got %0h expected no beat", cyc, got);
        end else begin
          exp_w = exp_q.pop_front();
          if (got !== exp_w) begin
            errors++;
            $display("FAIL beat_data: cycle %0d got %0h expected %0h", cyc, got, exp_w);
          end
        end
        if (got[DW]) begin
          model_frames++;
          in_frame = 0;
          gap_left = IFG;
        end else begin
          in_frame = 1;
        end
      end else if (gap_left > 0) begin
        gap_left--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit rand_ready);
    int n = 0;
    while ((exp_q.size() != 0 || gap_left > 0) && n < 300) begin
      if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    m_axis_tready = 1'b1;
    checks++;
    if (exp_q.size() != 0 || gap_left > 0) begin
      errors++;
      $display("FAIL drain_timeout: left %0d words gap %0d expected 0", exp_q.size(), gap_left);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; m_axis_tready = 1'b0;
    tick();
    tick();
    checks++;
    if ({fifo_rd_en, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, frame_count} !== '0) begin
      errors++;
      $display("FAIL reset_values: rd_en=%0b tvalid=%0b tdata=%0h tlast=%0b busy=%0b count=%0d expected all 0",
               fifo_rd_en, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, frame_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    int first_rd = -1, first_v = -1, hs_first = -1, hs_last = -1, nbeats = 0;
    enable = 1'b1; m_axis_tready = 1'b1;
    push_word(8'h11, 1'b0); push_word(8'h22, 1'b0);
    push_word(8'h33, 1'b0); push_word(8'h44, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_rd_en && first_rd < 0) first_rd = cyc;
      if (s_tvalid && first_v < 0) first_v = cyc;
      if (s_hs) begin
        nbeats++;
        if (hs_first < 0) hs_first = cyc;
        hs_last = cyc;
      end
    end
    checks++;
    if (first_v - first_rd != 2) begin
      errors++;
      $display("FAIL single_latency: got %0d expected 2", first_v - first_rd);
    end
    checks++;
    if (nbeats != 4 || hs_last - hs_first != 3) begin
      errors++;
      $display("FAIL single_back_to_back: got beats=%0d span=%0d expected beats=4 span=3", nbeats, hs_last - hs_first);
    end
    checks++;
    if (s_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_gap: got %0b expected 1", s_busy);
    end
    drain(1'b0);
    tick();
    checks++;
    if (s_busy !== 1'b0 || frame_count !== CW'(1)) begin
      errors++;
      $display("FAIL single_end: got busy=%0b count=%0d expected busy=0 count=1", s_busy, frame_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    enable = 1'b1; m_axis_tready = 1'b0;
    push_word(8'hA5, 1'b0); push_word(8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (s_tvalid !== 1'b1 || s_word !== {1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL reset_setup: got valid=%0b word=%0h expected valid=1 word=0a5", s_tvalid, s_word);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({fifo_rd_en, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, frame_count} !== '0) begin
      errors++;
      $display("FAIL reset_async: rd_en=%0b tvalid=%0b tdata=%0h tlast=%0b busy=%0b count=%0d expected all 0",
               fifo_rd_en, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, frame_count);
    end
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (s_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_stale_beat: cycle %0d got tvalid=%0b expected 0", cyc, s_tvalid);
      end
    end
  endtask

  task automatic test_gap();
    int ka = -1, kb = -1;
    enable = 1'b1; m_axis_tready = 1'b1;
    push_rand_frame(3);
    push_rand_frame(3);
    for (int i = 0; i < 60 && kb < 0; i++) begin
      tick();
      if (ka >= 0 && cyc == ka + IFG) begin
        checks++;
        if (rd_cnt - beat_cnt != 2) begin
          errors++;
          $display("FAIL gap_prefetch: got %0d expected 2", rd_cnt - beat_cnt);
        end
      end
      if (s_hs && ka >= 0 && kb < 0) kb = cyc;
      if (s_hs && s_word[DW] && ka < 0) ka = cyc;
    end
    checks++;
    if (kb - ka != IFG + 1) begin
      errors++;
      $display("FAIL gap_length: got %0d expected %0d", kb - ka - 1, IFG);
    end
    drain(1'b0);
  endtask

  task automatic test_backpressure();
    int base_rd, base_beat, n = 0;
    enable = 1'b1; m_axis_tready = 1'b1;
    base_rd = rd_cnt; base_beat = beat_cnt;
    push_rand_frame(8);
    while (beat_cnt - base_beat < 3 && n < 30) begin tick(); n++; end
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (s_tvalid !== 1'b1) begin
        errors++;
        $display("FAIL bp_valid: cycle %0d got %0b expected 1", cyc, s_tvalid);
      end
    end
    m_axis_tready = 1'b1;
    drain(1'b0);
    checks++;
    if (rd_cnt - base_rd != 8 || beat_cnt - base_beat != 8) begin
      errors++;
      $display("FAIL bp_totals: got reads=%0d beats=%0d expected 8 and 8", rd_cnt - base_rd, beat_cnt - base_beat);
    end
  endtask

  task automatic test_underrun();
    int base_beat, n = 0;
    enable = 1'b1; m_axis_tready = 1'b1;
    base_beat = beat_cnt;
    push_rand_frame(6);
    while (beat_cnt - base_beat < 2 && n < 30) begin tick(); n++; end
    force_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (s_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL underrun_rd_en: cycle %0d got %0b expected 0", cyc, s_rd_en);
      end
      if (i == 3) begin
        checks++;
        if (s_tvalid !== 1'b0 || s_busy !== 1'b1) begin
          errors++;
          $display("FAIL underrun_stall: got valid=%0b busy=%0b expected valid=0 busy=1", s_tvalid, s_busy);
        end
      end
    end
    force_empty = 1'b0;
    drain(1'b0);
  endtask

  task automatic test_enable();
    int n = 0;
    enable = 1'b0; m_axis_tready = 1'b1;
    push_rand_frame(2);
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (s_tvalid !== 1'b0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL enable_gate: got valid=%0b busy=%0b expected 0 and 0", s_tvalid, s_busy);
    end
    enable = 1'b1;
    while (!s_hs && n < 10) begin tick(); n++; end
    enable = 1'b0;
    drain(1'b0);
    enable = 1'b1;
  endtask

  task automatic test_counter_wrap();
    int exp_seq [5] = '{1, 2, 3, 0, 1};
    enable = 1'b0;
    do_reset();
    enable = 1'b1;
    for (int f = 0; f < 5; f++) begin
      push_rand_frame($urandom_range(1, 3));
      drain(1'b1);
      tick();
      checks++;
      if (frame_count !== CW'(exp_seq[f])) begin
        errors++;
        $display("FAIL count_wrap: frame %0d got %0d expected %0d", f, frame_count, exp_seq[f]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_reset_mid_frame();
    test_gap();
    test_backpressure();
    test_underrun();
    test_enable();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
